// File: rtl/ram_scan_pkg.sv
// Shared types and constants for the RAM scan sequencer.
// Holds the FSM state encoding, scan direction values and the RAM port source select.
package ram_scan_pkg;

   localparam int unsigned SCAN_WIDTH = 64;

   localparam logic DIR_SAVE    = 1'b0;
   localparam logic DIR_RESTORE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      OUT,
      IN,
      FIX,
      DONE
   } scan_state_t;

   typedef enum logic [1:0] {
      SEL_BLOCK,
      SEL_USER,
      SEL_SCAN
   } port_sel_t;

endpackage

// File: rtl/ram_port_mux.sv
// Selects who drives the RAM ports: emulated user logic, the scan sequencer, or nobody.
// Blocked drive holds both enables low; addresses and data are zeroed so they stay quiet.
module ram_port_mux
   import ram_scan_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  port_sel_t              i_sel,
   input  logic                   i_user_wen,
   input  logic                   i_user_ren,
   input  logic [ADDR_WIDTH-1:0]  i_user_waddr,
   input  logic [ADDR_WIDTH-1:0]  i_user_raddr,
   input  logic [DATA_WIDTH-1:0]  i_user_wdata,
   input  logic                   i_scan_wen,
   input  logic                   i_scan_ren,
   input  logic [ADDR_WIDTH-1:0]  i_scan_waddr,
   input  logic [ADDR_WIDTH-1:0]  i_scan_raddr,
   input  logic [DATA_WIDTH-1:0]  i_scan_wdata,
   output logic                   o_ram_wen,
   output logic                   o_ram_ren,
   output logic [ADDR_WIDTH-1:0]  o_ram_waddr,
   output logic [ADDR_WIDTH-1:0]  o_ram_raddr,
   output logic [DATA_WIDTH-1:0]  o_ram_wdata
);

   always_comb begin
      o_ram_wen   = 1'b0;
      o_ram_ren   = 1'b0;
      o_ram_waddr = '0;
      o_ram_raddr = '0;
      o_ram_wdata = '0;
      case (i_sel)
         SEL_USER: begin
            o_ram_wen   = i_user_wen;
            o_ram_ren   = i_user_ren;
            o_ram_waddr = i_user_waddr;
            o_ram_raddr = i_user_raddr;
            o_ram_wdata = i_user_wdata;
         end
         SEL_SCAN: begin
            o_ram_wen   = i_scan_wen;
            o_ram_ren   = i_scan_ren;
            o_ram_waddr = i_scan_waddr;
            o_ram_raddr = i_scan_raddr;
            o_ram_wdata = i_scan_wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ram_scan_ctrl.sv
// Owns the ports of one SRSW RAM: passes user accesses while running, and while halted
// walks every word to stream it out (save) or in (restore), then re-issues the last user read.
module ram_scan_ctrl
   import ram_scan_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_halt,
   input  logic                   i_start,
   input  logic                   i_dir,
   output logic                   o_busy,
   output logic                   o_done,
   input  logic                   i_user_wen,
   input  logic                   i_user_ren,
   input  logic [ADDR_WIDTH-1:0]  i_user_waddr,
   input  logic [ADDR_WIDTH-1:0]  i_user_raddr,
   input  logic [DATA_WIDTH-1:0]  i_user_wdata,
   output logic [DATA_WIDTH-1:0]  o_user_rdata,
   output logic                   o_ram_wen,
   output logic                   o_ram_ren,
   output logic [ADDR_WIDTH-1:0]  o_ram_waddr,
   output logic [ADDR_WIDTH-1:0]  o_ram_raddr,
   output logic [DATA_WIDTH-1:0]  o_ram_wdata,
   input  logic [DATA_WIDTH-1:0]  i_ram_rdata,
   output logic                   o_sdo_valid,
   input  logic                   i_sdo_ready,
   output logic [SCAN_WIDTH-1:0]  o_sdo_data,
   input  logic                   i_sdi_valid,
   output logic                   o_sdi_ready,
   input  logic [SCAN_WIDTH-1:0]  i_sdi_data
);

   scan_state_t             r_state;
   logic [ADDR_WIDTH-1:0]   r_ptr;
   logic [ADDR_WIDTH-1:0]   r_saved_raddr;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_sdo_valid;
   logic                    r_sdi_ready;

   port_sel_t               w_sel;
   logic                    w_last;
   logic                    w_scan_wen;
   logic                    w_scan_ren;
   logic [ADDR_WIDTH-1:0]   w_scan_raddr;
   logic                    w_unused_sdi;

   assign w_last = &r_ptr;

   // Sequencer: one word per RD/OUT pair on save, one word per accepted sdi beat on restore.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sdo_valid <= 1'b0;
         r_sdi_ready <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_done) r_busy <= 1'b0;
               if (i_halt && i_start && !r_busy) begin
                  r_ptr  <= '0;
                  r_busy <= 1'b1;
                  if (i_dir == DIR_RESTORE) begin
                     r_state     <= IN;
                     r_sdi_ready <= 1'b1;
                  end else begin
                     r_state <= RD;
                  end
               end
            end
            RD: begin
               r_state     <= OUT;
               r_sdo_valid <= 1'b1;
            end
            OUT: begin
               if (i_sdo_ready) begin
                  r_sdo_valid <= 1'b0;
                  if (w_last) begin
                     r_state <= FIX;
                  end else begin
                     r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                     r_state <= RD;
                  end
               end
            end
            IN: begin
               if (i_sdi_valid) begin
                  if (w_last) begin
                     r_sdi_ready <= 1'b0;
                     r_state     <= FIX;
                  end else begin
                     r_ptr <= r_ptr + ADDR_WIDTH'(1);
                  end
               end
            end
            FIX: r_state <= DONE;
            DONE: begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Last user read address, replayed in FIX so the RAM read output survives the scan.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_saved_raddr <= '0;
      end else if (i_user_ren && !i_halt) begin
         r_saved_raddr <= i_user_raddr;
      end
   end

   always_comb begin
      if (i_reset)               w_sel = SEL_BLOCK;
      else if (r_state != IDLE)  w_sel = SEL_SCAN;
      else if (i_halt)           w_sel = SEL_BLOCK;
      else                       w_sel = SEL_USER;
   end

   assign w_scan_wen   = (r_state == IN) && i_sdi_valid;
   assign w_scan_ren   = (r_state == RD) || (r_state == FIX);
   assign w_scan_raddr = (r_state == FIX) ? r_saved_raddr : r_ptr;
   assign w_unused_sdi = ^i_sdi_data;

   ram_port_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .i_sel        (w_sel),
      .i_user_wen   (i_user_wen),
      .i_user_ren   (i_user_ren),
      .i_user_waddr (i_user_waddr),
      .i_user_raddr (i_user_raddr),
      .i_user_wdata (i_user_wdata),
      .i_scan_wen   (w_scan_wen),
      .i_scan_ren   (w_scan_ren),
      .i_scan_waddr (r_ptr),
      .i_scan_raddr (w_scan_raddr),
      .i_scan_wdata (i_sdi_data[DATA_WIDTH-1:0]),
      .o_ram_wen    (o_ram_wen),
      .o_ram_ren    (o_ram_ren),
      .o_ram_waddr  (o_ram_waddr),
      .o_ram_raddr  (o_ram_raddr),
      .o_ram_wdata  (o_ram_wdata)
   );

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_sdo_valid  = r_sdo_valid;
   assign o_sdi_ready  = r_sdi_ready;
   assign o_sdo_data   = SCAN_WIDTH'(i_ram_rdata);
   assign o_user_rdata = i_ram_rdata;

endmodule

// File: doc/ram_scan_ctrl.md
Name: ram_scan_ctrl

Overview:
- Sequencer that owns the ports of one single-read/single-write RAM with registered read address (SRSW, raddr latched on ren).
- While running, passes user accesses through; while halted, blocks them.
- On command during halt, walks every RAM word: save streams contents out, restore streams contents in.
- Re-issues the last user read address afterwards so the RAM read output is unchanged on resume.
- Sits between emulated user logic and the RAM instance, feeding the emulator RAM scan path.

Parameters:
- ADDR_WIDTH, 2, RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width; must be <= 64.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- halt  in  1  emulation halted; user accesses blocked
- start  in  1  command pulse; accepted only in IDLE with halt=1
- dir  in  1  sampled with start; 0=save (RAM->sdo), 1=restore (sdi->RAM)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse at completion
- user_wen/user_ren  in  1 each  user write/read enables
- user_waddr/user_raddr  in  ADDR_WIDTH each  user addresses
- user_wdata  in  DATA_WIDTH  user write data
- user_rdata  out  DATA_WIDTH  equals ram_rdata
- ram_wen/ram_ren  out  1 each  RAM enables
- ram_waddr/ram_raddr  out  ADDR_WIDTH each  RAM addresses
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, mem[latched raddr]
- sdo_valid/sdo_ready  out/in  1 each  save stream handshake
- sdo_data  out  64  save word, zero-extended
- sdi_valid/sdi_ready  in/out  1 each  restore stream handshake
- sdi_data  in  64  restore word; low DATA_WIDTH bits used

Behaviour:
- Reset values: busy=0, done=0, sdo_valid=0, sdi_ready=0, ram_wen=0, ram_ren=0, ptr=0, saved_raddr=0, state IDLE. While reset is high, RAM enables are forced to 0.
- IDLE with halt=0: user_* drive ram_* combinationally.
- IDLE with halt=1: ram_wen=ram_ren=0.
- saved_raddr <= user_raddr on every cycle with user_ren=1 and halt=0.
- start is accepted in IDLE only when halt=1. Otherwise it is ignored, with no state change.
- On acceptance: ptr=0, busy=1 from the next cycle; next state is RD (dir=0) or IN (dir=1).
- RD: ram_ren=1, ram_raddr=ptr; next state OUT.
- OUT: ram_ren=0, sdo_valid=1, sdo_data={0,ram_rdata}. Data must stay stable until sdo_ready.
  - On handshake with ptr=DEPTH-1: go to FIX.
  - On handshake otherwise: ptr++, go to RD.
- IN: sdi_ready=1.
  - On sdi_valid: ram_wen=1, ram_waddr=ptr, ram_wdata=sdi_data[DATA_WIDTH-1:0], all in the same cycle.
  - Then with ptr=DEPTH-1: go to FIX; otherwise ptr++.
- FIX: ram_ren=1, ram_raddr=saved_raddr; next state DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- Throughput with sdo_ready=1 / sdi_valid=1 and DEPTH=4:
  - save: done asserted 10 cycles after the start edge;
  - restore: done asserted 6 cycles after the start edge.
- Backpressure: states wait indefinitely with no timeout.
- halt dropping mid-operation: the operation completes; user ports stay blocked until IDLE.
- start while busy: ignored.
- ptr wrap: never increments past DEPTH-1.
- Reset mid-operation: immediately IDLE, all handshakes deasserted, partial transfer abandoned with no done pulse. RAM contents are not restored.

Decomposition:
- Package ram_scan_pkg holds:
  - state enum (IDLE, RD, OUT, IN, FIX, DONE);
  - DIR_SAVE=0 and DIR_RESTORE=1 constants;
  - SCAN_WIDTH=64.
- One natural sub-module, ram_port_mux: combinational selection between user, scan and blocked drive of ram_*.

Test Plan:
- Run, no halt: write 0xA5A5A5A5 at addr 2, read addr 2 -> user_rdata=0xA5A5A5A5 next cycle, matching an unwrapped SRSW RAM model.
- Preload {0x11,0x22,0x33,0x44}, last user raddr=3, halt=1, start dir=0, sdo_ready=1 -> sdo words 0x11,0x22,0x33,0x44 in order; done at start+10; user_rdata=0x44 after done.
- Same save with sdo_ready toggling randomly -> identical word sequence, no word duplicated or dropped, sdo_data stable while sdo_valid&!sdo_ready.
- Restore dir=1, sdi words 0xDEAD0001..0xDEAD0004 back-to-back -> RAM holds those values at addrs 0..3; done at start+6; user_rdata reflects saved_raddr's new content.
- start with halt=0, and start while busy -> ignored; user writes during halt (wen=1, addr 1, data 0xFF) -> RAM unchanged.
- Assert reset during OUT of word 2 -> busy=0, sdo_valid=0 immediately; no done pulse; new save after reset streams all 4 words.
